// File: rtl/rr_out_arbiter.sv
// Round-robin wormhole arbiter for one router output: locks to an input from grant to tail, registered one-hot select.
// Grant is combinational from the lock, req and credits; a zero credit count or a dropped locked req stalls the input.
module rr_out_arbiter #(
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       req_in,
  input  logic [4:0]       tail_in,
  input  logic             credit_in,
  output logic [4:0]       sel_out,
  output logic [4:0]       grant_out,
  output logic             valid_out,
  output logic [CNT_W-1:0] credit_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic       lock_req;
  logic       have_credit;
  logic       tail_xfer;

  // First requester at or after the pointer, wrapping modulo 5.
  function automatic logic [4:0] rr_pick(input logic [4:0] req, input logic [2:0] start);
    logic [4:0] oh;
    logic [2:0] idx;
    oh = '0;
    for (int off = 4; off >= 0; off--) begin
      idx = 3'((int'(start) + off) % 5);
      if (req[idx]) oh = 5'b00001 << idx;
    end
    return oh;
  endfunction

  function automatic logic [2:0] next_of(input logic [4:0] oh);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 5; i++) begin
      if (oh[i]) n = (i == 4) ? 3'd0 : 3'(i + 1);
    end
    return n;
  endfunction

  assign lock_req    = |(req_in & sel_out);
  assign have_credit = (credit_cnt != '0);
  assign grant_out   = (state == BUSY && lock_req && have_credit) ? sel_out : '0;
  assign valid_out   = |grant_out;
  assign tail_xfer   = |(grant_out & tail_in);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      sel_out    <= '0;
      ptr        <= '0;
      credit_cnt <= CNT_W'(CREDITS);
    end else begin
      if (state == IDLE) begin
        if (|req_in) begin
          sel_out <= rr_pick(req_in, ptr);
          state   <= BUSY;
        end
      end else if (tail_xfer) begin
        state   <= IDLE;
        sel_out <= '0;
        ptr     <= next_of(sel_out);
      end

      // Transfer and returned credit in the same cycle cancel out.
      if (valid_out && !credit_in)
        credit_cnt <= credit_cnt - CNT_W'(1);
      else if (credit_in && !valid_out && credit_cnt != CNT_W'(CREDITS))
        credit_cnt <= credit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/rr_out_arbiter.md
Name: rr_out_arbiter

Overview:
- Per-output-port wormhole arbiter for the 5-port router (N, E, W, S, L).
- Sits directly upstream of the output crossbar mux. Its registered one-hot select drives the crossbar select input, and its grants pop the input FIFOs.
- Locks the output to one input from grant until that packet's tail flit has transferred.
- Tracks downstream buffer credits so that no flit is sent into a full neighbour FIFO.

Parameters:
- CREDITS, 4: downstream FIFO depth; initial and maximum credit count.
- CNT_W, 3: credit counter width; must satisfy 2^CNT_W > CREDITS.

Ports:
- clk, input, 1: router clock. All state updates on the rising edge.
- rst, input, 1: synchronous, active-low reset. Sampled on the clk rising edge; 0 = reset.
- req_in, input, 5: per-input request for this output, from the route computation of each input. Level, held while the input FIFO head targets this output.
- tail_in, input, 5: per-input flag; 1 = current head flit of that input is a tail flit. Single-flit packets have head = tail.
- credit_in, input, 1: one-cycle pulse; the downstream FIFO freed one slot.
- sel_out, output, 5: registered one-hot crossbar select, encoded as `L_PORT=00001, `S_PORT=00010, `W_PORT=00100, `E_PORT=01000, `N_PORT=10000. 0 = no selection; the crossbar then drives 0.
- grant_out, output, 5: combinational read-enable to input FIFOs; one-hot or 0.
- valid_out, output, 1: a flit is transferred on the output link this cycle; equals |grant_out.
- credit_cnt, output, CNT_W: current credit count, for debug and verification.

Behaviour:
- Index map: 0=L, 1=S, 2=W, 3=E, 4=N. sel_out bit i corresponds to index i.
- State: IDLE or BUSY. Registers: state, sel_out, ptr (3-bit, 0..4), credit counter.
- Reset (rst=0 at clock edge): state=IDLE, sel_out=0, ptr=0, credit_cnt=CREDITS. Consequently grant_out=0 and valid_out=0. Reset mid-packet abandons the lock with no tail required.
- IDLE:
  - If req_in != 0, pick the first index i with req_in[i]=1, searching ptr, ptr+1, ... mod 5.
  - Next cycle: sel_out = one-hot(i), state = BUSY.
  - Arbitration does not depend on credit.
  - If req_in = 0, stay IDLE with sel_out=0.
- Latency: a request sampled at edge t gives sel_out valid after edge t. The earliest flit transfer is in the cycle following t.
- BUSY, locked index k:
  - grant_out = sel_out when req_in[k]=1 and credit_cnt != 0; else 0.
  - Requests from other inputs are ignored.
  - A drop of req_in[k] without a tail transfer keeps the lock (wormhole stall); grant_out=0.
  - A transfer with tail_in[k]=1 causes, at the next edge: state=IDLE, sel_out=0, ptr=(k+1) mod 5.
  - There is exactly one bubble cycle between packets. Back-to-back packets from the same input rearbitrate normally.
- Credits:
  - On a transfer cycle without credit_in: credit_cnt - 1.
  - On credit_in without a transfer: +1, saturating at CREDITS (an excess credit is dropped).
  - On a transfer and credit_in in the same cycle: unchanged.
  - At credit_cnt=0: no grant. A credit_in arriving in that cycle allows a grant only from the next cycle (no combinational path from credit_in to grant_out).
- grant_out and valid_out are never asserted in IDLE.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, req_in=0 -> sel_out=00000, grant_out=0, credit_cnt=4; all remain so for 10 cycles.
- Single-flit packet:
  - Stimulus: req_in=00100 with tail_in=00100 at cycle 1.
  - Response: sel_out=00100 after edge 1; grant_out=00100 for one cycle; then IDLE, sel_out=0, ptr=3; credit_cnt=3.
- Round-robin fairness: req_in=11111 continuously, every flit a tail, credit_in pulsed each transfer -> grant order L, S, W, E, N, L, with one idle cycle between grants.
- Wormhole lock:
  - Stimulus: E sends a 4-flit packet (tail on flit 4) while N requests throughout; E drops its req for 2 cycles after flit 2.
  - Response: sel_out stays 01000 through the gap; N is granted only after E's tail plus a bubble.
- Credit exhaustion:
  - Stimulus: CREDITS=4, no credit_in, 6-flit packet from L.
  - Response: 4 grants, then grant_out=0 with credit_cnt=0. A credit_in pulse yields exactly one more grant one cycle later.
- Simultaneous events and reset mid-packet:
  - Transfer plus credit_in in the same cycle -> credit_cnt unchanged.
  - credit_in at credit_cnt=4 -> stays 4.
  - rst=0 during flit 2 of S's packet -> IDLE, sel_out=0, ptr=0, credit_cnt=4 after that edge.
